// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and the
// iterative multiply/divide unit.
//
// Signals (all driven/sampled on the rising clk edge of the enclosing design):
//   Start   master->slave  launch an op; only looked at while the unit is idle
//   Funct3  master->slave  RV32M op select (MUL..REMU)
//   Kill    master->slave  flush: abort whatever is in flight, no Done
//   SrcA    master->slave  rs1 operand (multiplicand / dividend)
//   SrcB    master->slave  rs2 operand (multiplier / divisor)
//   Busy    slave->master  high while iterating
//   Done    slave->master  one-cycle pulse, Result valid in that cycle
//   Result  slave->master  last completed result, held between ops
//
// Handshake: Start acts as "valid" and is accepted on any rising edge where
// the unit is idle and Kill is low; there is no separate ready, so the master
// must keep Start/Funct3/SrcA/SrcB stable until that edge. Done is the
// response strobe; it is not acknowledged and lasts exactly one cycle.
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [2:0]            Funct3;
  logic                  Kill;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Result;

  modport master (
    output Start, Funct3, Kill, SrcA, SrcB,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Funct3, Kill, SrcA, SrcB,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit sitting beside the ALU.
// Multiplies by shift-add and divides by restoring shift-subtract, both on
// operand magnitudes, one radix-2 step per cycle, with the sign fixed up in a
// final cycle. Divide-by-zero and signed overflow are resolved at launch.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; returns the unit to IDLE, clears all
//   bus        muldiv_if.slave (Start/Funct3/Kill/SrcA/SrcB in,
//              Busy/Done/Result out)
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  muldiv_if.slave    bus,
  output logic [1:0] dbg_state
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  // Steps 0..W-1 iterate; the count W is the sign-fixup / writeback cycle.
  localparam logic [CW-1:0] LAST_STEP = CW'(W);
  localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [2:0]      op_q,     op_d;
  // Multiply: {partial high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [2*W-1:0]  acc_q,    acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [W-1:0]    opb_q,    opb_d;
  logic            neg_q,    neg_d;   // negate product / quotient
  logic            rneg_q,   rneg_d;  // negate remainder
  logic [W-1:0]    result_q, result_d;

  // Launch-time operand decode.
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]    a_mag, b_mag, special_res;

  always_comb begin
    // Divides: signed unless Funct3[0]. Multiplies: rs1 signed for
    // MUL/MULH/MULHSU, rs2 signed for MUL/MULH (MUL low half is sign-agnostic).
    a_signed    = bus.Funct3[2] ? ~bus.Funct3[0] : (bus.Funct3[1:0] != 2'b11);
    b_signed    = bus.Funct3[2] ? ~bus.Funct3[0] : ~bus.Funct3[1];
    a_neg       = a_signed & bus.SrcA[W-1];
    b_neg       = b_signed & bus.SrcB[W-1];
    a_mag       = a_neg ? -bus.SrcA : bus.SrcA;
    b_mag       = b_neg ? -bus.SrcB : bus.SrcB;
    div_zero    = bus.Funct3[2] & (bus.SrcB == '0);
    div_ovf     = bus.Funct3[2] & ~bus.Funct3[0] &
                  (bus.SrcA == MIN_NEG) & (bus.SrcB == '1);
    special_res = div_zero ? (bus.Funct3[1] ? bus.SrcA : '1)
                           : (bus.Funct3[1] ? '0 : MIN_NEG);
  end

  // Per-step datapath and final sign fixup.
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    // Bit W of the difference is the borrow: set means the divisor did not fit.
    div_diff  = div_shift - {1'b0, opb_q};
    prod_fix  = neg_q  ? -acc_q            : acc_q;
    quo_fix   = neg_q  ? -acc_q[W-1:0]     : acc_q[W-1:0];
    rem_fix   = rneg_q ? -acc_q[2*W-1:W]   : acc_q[2*W-1:W];
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (bus.Start && !bus.Kill) begin
          op_d   = bus.Funct3;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d = CALC;
            if (bus.Funct3[2]) begin
              acc_d = {{W{1'b0}}, a_mag};
              opb_d = b_mag;
            end else begin
              acc_d = {{W{1'b0}}, b_mag};
              opb_d = a_mag;
            end
          end
        end
      end
      CALC: begin
        if (cnt_q == LAST_STEP) begin
          result_d = final_res;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q[2]) begin
            acc_d = {(div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0]),
                     acc_q[W-2:0], ~div_diff[W]};
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a completing op.
    if (bus.Kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign bus.Busy   = (state_q == CALC);
  assign bus.Done   = (state_q == DONE) && !bus.Kill;
  assign bus.Result = result_q;
  assign dbg_state  = state_q;
endmodule
